ami_rd_split: RTL and testbench
===============================

# ami_rd_split

Read-command splitter placed directly upstream of the AXI master read interface. It takes a single linear read command (start address, byte count, ID). It breaks the command into INCR bursts of at most BL beats, and no burst crosses a 4 KB boundary. It drives those bursts into the interface's user AR port. It also watches the user R port for burst completions and pulses a done/error status when every burst of the command has returned. The interface's usr_clk is tied to ACLK when the two blocks are paired.

## Interface
- AXI_DW, 128: data bus width; beat size AXI_BYTES = AXI_DW/8, L = log2(AXI_BYTES)
- AXI_AW, 32: address width
- AXI_IW, 8: ID width
- AXI_LW, 8: ARLEN width
- AXI_SW, 3: ARSIZE width
- BL, 16: maximum beats per burst (power of 2, ≤ 256)
- CMD_BW, 32: command byte-count width
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- cmd_id  in  AXI_IW  ID applied to every burst of the command
- cmd_addr  in  AXI_AW  start byte address; low L bits ignored (treated as 0)
- cmd_bytes  in  CMD_BW  byte count; low L bits ignored; beats = cmd_bytes >> L
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- usr_arid / usr_araddr / usr_arlen / usr_arsize / usr_arburst  out  AXI_IW / AXI_AW / AXI_LW / AXI_SW / 2  burst request
- usr_arvalid  out  1  request valid
- usr_arready  in  1  request accepted
- mon_rvalid, mon_rready, mon_rlast  in  1 each  snoop of user R handshake (block never drives rready)
- mon_rresp  in  2  snooped response
- done  out  1  one-cycle completion pulse
- done_err  out  1  valid with done; 1 if any beat returned rresp[1]=1 (SLVERR/DECERR)

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch id, addr (low L bits zeroed), rem = beats, clear issued/completed counters and err.
  - If beats==0, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - usr_arvalid=1.
  - Burst length n = min(rem, BL, (4096 − addr[11:0]) >> L). n is computed combinationally from registered addr/rem only, so it is stable while stalled.
  - usr_arlen = n−1, usr_araddr = addr, usr_arsize = L, usr_arburst = INCR (2'b01).
  - On handshake: addr += n<<L, rem −= n, issued++.
  - If rem==n on that handshake, go to WAIT; otherwise stay in ISSUE with arvalid held high.
- WAIT:
  - When completed_next == issued, go to DONE.
- Completion counting, active in every state except IDLE:
  - Each mon_rvalid & mon_rready & mon_rlast increments completed, but never beyond issued; stray rlasts are ignored.
  - Each accepted beat with mon_rresp[1] sets err (sticky).
  - Completions may coincide with AR handshakes; both counters update in the same cycle.
- DONE: done=1, done_err=err; go to IDLE the next cycle.
- Counter width for issued/completed/rem: CMD_BW − L bits. addr wraps modulo 2^AXI_AW.

## Timing
- Reset values:
  - cmd_ready=1 (the block is in IDLE).
  - usr_arvalid=0, done=0, done_err=0.
  - usr_ar* payload = 0.
  - All counters = 0; state = IDLE.
- Command accept (cycle t) → first usr_arvalid at t+1.
- AR throughput: one burst per cycle when usr_arready is held high. The payload must not change while arvalid is high and arready is low.
- Last R handshake of the command (cycle t) → done at t+1. The block reaches DONE in the cycle after WAIT sees the final completion. If the final rlast coincides with the last AR handshake, the block passes through WAIT for one cycle.
- Zero-beat command: accept at t, done (err=0) at t+1, no AR issued.
- Next command can be accepted the cycle after done.
- ARESETn asserted mid-command: the block immediately returns to reset values. R beats still in flight from the aborted command are ignored, because the completion counter is clamped by issued=0.

## Structure
- Shared package ami_pkg holds:
  - AXI_BURST_INCR = 2'b01 and the AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - the split state enum
  - a function beats_to_4k(addr, L)
- Single module; no sub-module needed. The burst-length min() logic stays as one combinational always block.

## Test plan
- DW=128, addr 0x0000_0FF0, bytes 0x120, arready held high → three bursts: (0x0FF0, len 0), (0x1000, len 15), (0x1100, len 0) on consecutive cycles. done one cycle after the third rlast, done_err=0.
- addr 0x2000, bytes 0x400 (64 beats), arready toggling 1/0 → four bursts, len 15 each, at 0x2000/0x2100/0x2200/0x2300. Payload is stable during every stall.
- bytes 0x0 → no usr_arvalid; done=1, done_err=0 exactly one cycle after acceptance; cmd_ready back to 1 the next cycle.
- 2-burst command, second burst returns rresp=2'b10 on a middle beat → done with done_err=1. A following clean command ends with done_err=0.
- Final rlast in the same cycle as the last AR handshake → done still asserts only after completed==issued. Extra stray rlast in IDLE → no done, and counters remain 0.
- ARESETn asserted while in ISSUE with 2 bursts outstanding → all outputs return to reset values. Late rlasts after reset release produce no done; a new command then completes normally.

Source files
------------

// File: rtl/ami_pkg.sv
// ami_pkg: shared AXI constants, read-splitter state enum and 4 KB room helper
package ami_pkg;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} split_state_e;
  // beats of 2^l bytes left before the next 4 KB page starts
  function automatic logic [12:0] beats_to_4k(input logic [11:0] addr, input int unsigned l);
    return 13'((13'd4096 - {1'b0, addr}) >> l);
  endfunction
endpackage

// File: rtl/ami_rd_split.sv
// ami_rd_split: splits one linear read command into 4 KB-safe INCR bursts and reports completion
//   cmd_*         : command in (id, start address, byte count), cmd_ready high only when idle
//   usr_ar*       : burst requests toward the AXI master user AR port
//   mon_r*        : passive snoop of the user R handshake used to count returned bursts
//   done/done_err : one-cycle completion pulse, done_err set if any beat came back SLVERR/DECERR
module ami_rd_split
  import ami_pkg::*;
#(
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3,
  parameter int BL     = 16,
  parameter int CMD_BW = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [AXI_IW-1:0] cmd_id,
  input  logic [AXI_AW-1:0] cmd_addr,
  input  logic [CMD_BW-1:0] cmd_bytes,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [AXI_IW-1:0] usr_arid,
  output logic [AXI_AW-1:0] usr_araddr,
  output logic [AXI_LW-1:0] usr_arlen,
  output logic [AXI_SW-1:0] usr_arsize,
  output logic [1:0]        usr_arburst,
  output logic              usr_arvalid,
  input  logic              usr_arready,
  input  logic              mon_rvalid,
  input  logic              mon_rready,
  input  logic              mon_rlast,
  input  logic [1:0]        mon_rresp,
  output logic              done,
  output logic              done_err
);
  localparam int L  = $clog2(AXI_DW / 8);
  localparam int CW = CMD_BW - L;
  split_state_e      state_q, state_d;
  logic [AXI_IW-1:0] id_q, id_d;
  logic [AXI_AW-1:0] addr_q, addr_d;
  logic [CW-1:0]     rem_q, rem_d, issued_q, issued_d, comp_q, comp_d;
  logic [CW-1:0]     n, room, beats;
  logic              err_q, err_d, ar_hs, r_hs, r_done;
  logic              unused_ok;
  assign unused_ok = ^{mon_rresp[0], cmd_addr[L-1:0], cmd_bytes[L-1:0]};
  assign beats  = cmd_bytes[CMD_BW-1:L];
  assign ar_hs  = usr_arvalid & usr_arready;
  assign r_hs   = mon_rvalid & mon_rready;
  // completions are clamped to issued so stray or stale rlasts never count
  assign r_done = r_hs & mon_rlast & (comp_q < issued_q);
  // burst length depends only on registered state, so it holds steady across AR stalls
  always_comb begin
    room = CW'(beats_to_4k(addr_q[11:0], L));
    n    = rem_q < CW'(BL) ? rem_q : CW'(BL);
    n    = room < n ? room : n;
  end
  // payload is zeroed outside ISSUE so idle outputs match the reset values
  assign usr_arvalid = state_q == S_ISSUE;
  assign usr_arid    = usr_arvalid ? id_q : '0;
  assign usr_araddr  = usr_arvalid ? addr_q : '0;
  assign usr_arlen   = usr_arvalid ? AXI_LW'(n - CW'(1)) : '0;
  assign usr_arsize  = usr_arvalid ? AXI_SW'(L) : '0;
  assign usr_arburst = usr_arvalid ? AXI_BURST_INCR : 2'b00;
  assign cmd_ready   = state_q == S_IDLE;
  assign done        = state_q == S_DONE;
  assign done_err    = done & err_q;
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    issued_d = issued_q;
    comp_d   = comp_q;
    err_d    = err_q;
    if (state_q != S_IDLE) begin
      comp_d = r_done ? comp_q + CW'(1) : comp_q;
      err_d  = err_q | (r_hs & mon_rresp[1]);
    end
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        id_d     = cmd_id;
        addr_d   = {cmd_addr[AXI_AW-1:L], {L{1'b0}}};
        rem_d    = beats;
        issued_d = '0;
        comp_d   = '0;
        err_d    = 1'b0;
        state_d  = beats == '0 ? S_DONE : S_ISSUE;
      end
      S_ISSUE: if (ar_hs) begin
        addr_d   = addr_q + (AXI_AW'(n) << L);
        rem_d    = rem_q - n;
        issued_d = issued_q + CW'(1);
        state_d  = rem_q == n ? S_WAIT : S_ISSUE;
      end
      S_WAIT: state_d = comp_d == issued_q ? S_DONE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      issued_q <= '0;
      comp_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      issued_q <= issued_d;
      comp_q   <= comp_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_ami_rd_split.sv
// tb_ami_rd_split: directed and randomized checks of ami_rd_split against a burst-plan model
module tb_ami_rd_split;
  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [7:0]  cmd_id = '0;
  logic [31:0] cmd_addr = '0, cmd_bytes = '0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [7:0]  usr_arid, usr_arlen;
  logic [31:0] usr_araddr;
  logic [2:0]  usr_arsize;
  logic [1:0]  usr_arburst;
  logic        usr_arvalid, usr_arready = 1'b0;
  logic        mon_rvalid = 1'b0, mon_rready = 1'b0, mon_rlast = 1'b0;
  logic [1:0]  mon_rresp = '0;
  logic        done, done_err;
  int          tests = 0, fails = 0;
  logic [31:0] exp_addr[$];
  int          exp_len[$];

  always #5 ACLK = ~ACLK;

  ami_rd_split dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .usr_arid(usr_arid), .usr_araddr(usr_araddr), .usr_arlen(usr_arlen),
    .usr_arsize(usr_arsize), .usr_arburst(usr_arburst),
    .usr_arvalid(usr_arvalid), .usr_arready(usr_arready),
    .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rlast(mon_rlast),
    .mon_rresp(mon_rresp), .done(done), .done_err(done_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_arvalid"}, 64'(usr_arvalid), 64'd0);
    check({tag, "_payload"}, 64'({usr_arid, usr_araddr, usr_arlen, usr_arsize, usr_arburst}), 64'd0);
    check({tag, "_done"}, 64'({done, done_err}), 64'd0);
  endtask

  // expected bursts: 16-byte beats, at most 16 per burst, never past a 4 KB page
  task automatic plan(input logic [31:0] addr, input logic [31:0] bytes);
    longint a = longint'(addr) & 64'hFFFF_FFF0;
    longint r = longint'(bytes) / 16;
    longint n, room;
    exp_addr.delete();
    exp_len.delete();
    while (r > 0) begin
      room = (4096 - (a % 4096)) / 16;
      n = r < 16 ? r : 16;
      if (room < n) n = room;
      exp_addr.push_back(a[31:0]);
      exp_len.push_back(int'(n));
      a = (a + n * 16) % 64'h1_0000_0000;
      r -= n;
    end
  endtask

  task automatic stray_rlasts(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      mon_rvalid = 1'b1;
      mon_rready = 1'b1;
      mon_rlast  = 1'b1;
      mon_rresp  = 2'b10;
      tick();
      check("stray_done", 64'(done), 64'd0);
      check("stray_cmd_ready", 64'(cmd_ready), 64'd1);
    end
    mon_rvalid = 1'b0;
    mon_rready = 1'b0;
    mon_rlast  = 1'b0;
    mon_rresp  = 2'b00;
  endtask

  // ar_mode: 0 always ready, 1 toggling, 2 random, 3 ready only with an rlast or when nothing is outstanding
  // err_mode: 0 clean, 1 SLVERR mid-beat of the second burst, 2 random responses
  task automatic run_cmd(input logic [7:0] id, input logic [31:0] addr, input logic [31:0] bytes,
                         input int ar_mode, input int err_mode);
    int nb, issued = 0, completed = 0, beat = 0, cyc = 0, rr;
    int q[$];
    bit err = 0, done_due = 0, seen = 0, tog = 1, last_hs;
    plan(addr, bytes);
    nb = exp_len.size();
    mon_rvalid = 1'b0;
    mon_rready = 1'b0;
    mon_rlast  = 1'b0;
    mon_rresp  = 2'b00;
    usr_arready = 1'b0;
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_id = id;
    cmd_addr = addr;
    cmd_bytes = bytes;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    done_due = nb == 0;
    while (!seen && cyc < 3000) begin
      check("done", 64'(done), 64'(done_due));
      if (done_due) begin
        check("done_err", 64'(done_err), 64'(err));
        seen = 1;
      end
      check("arvalid", 64'(usr_arvalid), 64'(issued < nb));
      if (issued < nb)
        check("ar_payload", 64'({usr_arid, usr_araddr, usr_arlen, usr_arsize, usr_arburst}),
              64'({id, exp_addr[issued], 8'(exp_len[issued] - 1), 3'd4, 2'b01}));
      done_due = 0;
      last_hs = 0;
      mon_rvalid = 1'b0;
      mon_rready = 1'b0;
      mon_rlast  = 1'b0;
      mon_rresp  = 2'b00;
      if (q.size() > 0) begin
        mon_rvalid = ($urandom % 4) != 0;
        mon_rready = ($urandom % 4) != 0;
        mon_rlast  = beat == q[0] - 1;
        rr = int'($urandom % 16);
        mon_rresp = err_mode == 1 ? ((completed == 1 && beat == q[0] / 2) ? 2'b10 : 2'b00)
                  : err_mode == 2 ? (rr == 0 ? 2'b10 : rr == 1 ? 2'b11 : rr == 2 ? 2'b01 : 2'b00)
                  : 2'b00;
        if (mon_rvalid && mon_rready) begin
          if (mon_rresp[1]) err = 1;
          if (mon_rlast) begin
            void'(q.pop_front());
            beat = 0;
            completed++;
            last_hs = 1;
            done_due = completed == nb;
          end else beat++;
        end
      end
      usr_arready = ar_mode == 0 ? 1'b1 : ar_mode == 1 ? tog
                  : ar_mode == 2 ? 1'($urandom % 2) : (q.size() == 0 || last_hs);
      tog = !tog;
      if (issued < nb && usr_arready) begin
        q.push_back(exp_len[issued]);
        issued++;
      end
      tick();
      cyc++;
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    else begin
      check("after_done_cmd_ready", 64'(cmd_ready), 64'd1);
      check("after_done_quiet", 64'({done, usr_arvalid}), 64'd0);
    end
    usr_arready = 1'b0;
  endtask

  initial begin
    #2;
    check_reset_outputs("reset");
    tick();
    tick();
    ARESETn = 1'b1;
    tick();
    check_reset_outputs("post_reset");
    run_cmd(8'h11, 32'h0000_0FF0, 32'h120, 0, 0);
    run_cmd(8'h22, 32'h0000_2000, 32'h400, 1, 0);
    run_cmd(8'h33, 32'h0000_1234, 32'h0, 0, 0);
    run_cmd(8'h3A, 32'h0000_1230, 32'hF, 2, 0);
    run_cmd(8'h44, 32'h0000_3F80, 32'h180, 0, 1);
    run_cmd(8'h45, 32'h0000_5000, 32'h200, 0, 0);
    run_cmd(8'h55, 32'h0000_6000, 32'h300, 3, 0);
    stray_rlasts(3);
    run_cmd(8'h56, 32'h0000_0FE0, 32'h40, 0, 0);
    // abort a command with two bursts already accepted
    cmd_id = 8'h66;
    cmd_addr = 32'h0000_7000;
    cmd_bytes = 32'h400;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    usr_arready = 1'b1;
    tick();
    tick();
    check("abort_arvalid_before", 64'(usr_arvalid), 64'd1);
    usr_arready = 1'b0;
    ARESETn = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    ARESETn = 1'b1;
    stray_rlasts(4);
    run_cmd(8'h77, 32'h0000_7000, 32'h400, 2, 0);
    for (int i = 0; i < 12; i++)
      run_cmd(8'($urandom), $urandom, $urandom_range(0, 32'h800), int'($urandom_range(0, 3)), 2);
    run_cmd(8'h88, 32'hFFFF_FFC0, 32'h100, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
